// File: rtl/conv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : conv_pkg                                                     |
// | Description : Shared constants, types and helpers for the Sobel edge       |
// |               detector (luma coefficients, data widths, pipeline latency). |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package conv_pkg;

   localparam int LAT      = 4;     // input-to-output latency in cycles
   localparam int Y_COEF_R = 77;    // luma weights, sum to 256
   localparam int Y_COEF_G = 150;
   localparam int Y_COEF_B = 29;
   localparam int PIX_W    = 16;    // RGB565 pixel
   localparam int Y_W      = 8;     // luma sample
   localparam int G_W      = 11;    // signed gradient (|G| <= 1020)
   localparam int CNT_W    = 11;    // column / line counters

   // Control signals that travel alongside the pixel pipeline.
   typedef struct packed {
      logic de;
      logic hs;
      logic vs;
   } sync_t;

   // Zero-extend a luma sample into the signed gradient domain.
   function automatic logic signed [G_W-1:0] y_ext(input logic [Y_W-1:0] y);
      return $signed({{(G_W-Y_W){1'b0}}, y});
   endfunction

endpackage
`default_nettype wire

// File: rtl/rgb565_to_y.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rgb565_to_y                                                  |
// | Description : Registered RGB565 -> 8-bit luma conversion, 1-cycle latency. |
// | Ports       : pclk - clock (rising edge)                                   |
// |               rst  - synchronous active-high reset                         |
// |               pix  - RGB565 input pixel                                    |
// |               y    - registered luma output                                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rgb565_to_y
   import conv_pkg::*;
(
   input  logic             pclk,
   input  logic             rst,
   input  logic [PIX_W-1:0] pix,
   output logic [Y_W-1:0]   y
);

   logic [7:0]  r8;
   logic [7:0]  g8;
   logic [7:0]  b8;
   logic [15:0] sum;
   logic [7:0]  y_next;

   // Channel expansion replicates the MSBs so full-scale maps to 255; with
   // weights summing to 256, white gives exactly 255 after the shift and the
   // 16-bit sum can never overflow (max 65280).
   always_comb begin
      r8     = {pix[15:11], pix[15:13]};
      g8     = {pix[10:5],  pix[10:9]};
      b8     = {pix[4:0],   pix[4:2]};
      sum    = 16'(Y_COEF_R) * {8'd0, r8}
             + 16'(Y_COEF_G) * {8'd0, g8}
             + 16'(Y_COEF_B) * {8'd0, b8};
      y_next = 8'(sum >> 8);
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         y <= '0;
      end else begin
         y <= y_next;
      end
   end

endmodule
`default_nettype wire

// File: rtl/conv_sobel3x3.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : conv_sobel3x3                                                |
// | Description : 3x3 Sobel edge detector on a 3-row RGB565 stream. Four       |
// |               stages: luma, window shift, gradients, magnitude/threshold.  |
// | Ports       : pclk, rst              - clock, sync active-high reset       |
// |               in_de, in_hs, in_vs    - input data enable / line / frame    |
// |               row1_in..row3_in       - oldest / centre / newest line pixel |
// |               thresh                 - edge threshold                      |
// |               out_de, out_hs, out_vs - syncs delayed by LAT                 |
// |               out_data               - 16'hFFFF on edge, else 0            |
// |               edge_flag              - 1 when the pixel is an edge         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module conv_sobel3x3
   import conv_pkg::*;
#(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480
)(
   input  logic             pclk,
   input  logic             rst,
   input  logic             in_de,
   input  logic             in_hs,
   input  logic             in_vs,
   input  logic [PIX_W-1:0] row1_in,
   input  logic [PIX_W-1:0] row2_in,
   input  logic [PIX_W-1:0] row3_in,
   input  logic [7:0]       thresh,
   output logic             out_de,
   output logic             out_hs,
   output logic             out_vs,
   output logic [PIX_W-1:0] out_data,
   output logic             edge_flag
);

   localparam int               CNT_MAX = (1 << CNT_W) - 1;
   localparam logic [CNT_W-1:0] CNT_SAT = '1;

   // Configured geometry must fit the counters.
   if (H_ACTIVE < 1 || H_ACTIVE > CNT_MAX || V_ACTIVE < 1 || V_ACTIVE > CNT_MAX) begin : g_geom_check
      $error("conv_sobel3x3: H_ACTIVE/V_ACTIVE exceed counter range");
   end

   // ---------------- column / line tracking at the input side -------------
   logic [CNT_W-1:0] col_cnt;
   logic [CNT_W-1:0] line_cnt;
   logic             de_prev;
   logic             vs_prev;
   logic             frc_in;

   always_ff @(posedge pclk) begin
      if (rst) begin
         col_cnt  <= '0;
         line_cnt <= '0;
         de_prev  <= 1'b0;
         vs_prev  <= 1'b0;
      end else begin
         de_prev <= in_de;
         vs_prev <= in_vs;
         if (!in_de) begin
            col_cnt <= '0;
         end else if (col_cnt != CNT_SAT) begin
            col_cnt <= col_cnt + 1'b1;
         end
         if (in_vs && !vs_prev) begin
            line_cnt <= '0;
         end else if (de_prev && !in_de && line_cnt != CNT_SAT) begin
            line_cnt <= line_cnt + 1'b1;
         end
      end
   end

   // col_cnt is the index of the current input beat, which is also the output
   // column k this beat produces; the first two columns and first two lines
   // see an incomplete window and are forced black.
   assign frc_in = (col_cnt < CNT_W'(2)) || (line_cnt < CNT_W'(2));

   // ---------------- control pipeline --------------------------------------
   sync_t          sync_pipe [LAT];
   logic [LAT-2:0] frc_pipe;       // bit i = force flag at stage i+1

   always_ff @(posedge pclk) begin
      if (rst) begin
         for (int i = 0; i < LAT; i++) sync_pipe[i] <= '0;
         frc_pipe <= '0;
      end else begin
         sync_pipe[0] <= '{de: in_de, hs: in_hs, vs: in_vs};
         for (int i = 1; i < LAT; i++) sync_pipe[i] <= sync_pipe[i-1];
         frc_pipe <= {frc_pipe[LAT-3:0], frc_in};
      end
   end

   assign out_de = sync_pipe[LAT-1].de;
   assign out_hs = sync_pipe[LAT-1].hs;
   assign out_vs = sync_pipe[LAT-1].vs;

   // ---------------- stage 1: luma per row ---------------------------------
   logic [PIX_W-1:0] row_pix [3];
   logic [Y_W-1:0]   y_row   [3];

   assign row_pix[0] = row1_in;
   assign row_pix[1] = row2_in;
   assign row_pix[2] = row3_in;

   for (genvar r = 0; r < 3; r++) begin : g_luma
      rgb565_to_y u_luma (
         .pclk (pclk),
         .rst  (rst),
         .pix  (row_pix[r]),
         .y    (y_row[r])
      );
   end

   // ---------------- stage 2: 3x3 window -----------------------------------
   // win[row][col]; col 0 is the oldest (left) column, col 2 the newest.
   logic [Y_W-1:0] win [3][3];

   always_ff @(posedge pclk) begin
      if (rst) begin
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
               win[r][c] <= '0;
      end else if (sync_pipe[0].de) begin
         for (int r = 0; r < 3; r++) begin
            win[r][0] <= win[r][1];
            win[r][1] <= win[r][2];
            win[r][2] <= y_row[r];
         end
      end
   end

   // ---------------- stage 3: Sobel gradients ------------------------------
   logic signed [G_W-1:0] gx_c;
   logic signed [G_W-1:0] gy_c;
   logic signed [G_W-1:0] gx;
   logic signed [G_W-1:0] gy;

   always_comb begin
      gx_c = (y_ext(win[0][2]) - y_ext(win[0][0]))
           + ((y_ext(win[1][2]) - y_ext(win[1][0])) <<< 1)
           + (y_ext(win[2][2]) - y_ext(win[2][0]));
      gy_c = (y_ext(win[2][0]) + (y_ext(win[2][1]) <<< 1) + y_ext(win[2][2]))
           - (y_ext(win[0][0]) + (y_ext(win[0][1]) <<< 1) + y_ext(win[0][2]));
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         gx <= '0;
         gy <= '0;
      end else begin
         gx <= gx_c;
         gy <= gy_c;
      end
   end

   // ---------------- stage 4: magnitude, threshold, output -----------------
   logic [G_W-1:0] ax;
   logic [G_W-1:0] ay;
   logic [G_W:0]   mag;
   logic [7:0]     mag_sat;
   logic           is_edge;

   always_comb begin
      ax      = gx[G_W-1] ? G_W'(-gx) : G_W'(gx);
      ay      = gy[G_W-1] ? G_W'(-gy) : G_W'(gy);
      mag     = {1'b0, ax} + {1'b0, ay};
      mag_sat = (mag > (G_W+1)'(255)) ? 8'hFF : mag[7:0];
      // Blank/forced pixels win over the comparison, so thresh = 0 cannot
      // light them up.
      is_edge = sync_pipe[LAT-2].de && !frc_pipe[LAT-2] && (mag_sat >= thresh);
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         edge_flag <= 1'b0;
         out_data  <= '0;
      end else begin
         edge_flag <= is_edge;
         out_data  <= {PIX_W{is_edge}};
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_conv_sobel3x3.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_conv_sobel3x3                                             |
// | Description : Scoreboard bench for conv_sobel3x3: the driver pushes the    |
// |               expected result of every input beat, the monitor pops and    |
// |               compares whenever out_de is presented.                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_conv_sobel3x3;

   localparam int M_FLAT  = 0;   // all white, thresh 1   -> all black
   localparam int M_VERT  = 1;   // step at column 8, 128 -> white k=8,9
   localparam int M_HORIZ = 2;   // row1 black, rows 2/3 white, 255 -> k>=2
   localparam int M_ZERO  = 3;   // all white, thresh 0   -> k>=2

   logic        pclk = 1'b0;
   logic        rst  = 1'b1;
   logic        in_de = 1'b0, in_hs = 1'b0, in_vs = 1'b0;
   logic [15:0] row1_in = '0, row2_in = '0, row3_in = '0;
   logic [7:0]  thresh = '0;
   logic        out_de, out_hs, out_vs, edge_flag;
   logic [15:0] out_data;

   always #5 pclk = ~pclk;

   conv_sobel3x3 #(.H_ACTIVE(640), .V_ACTIVE(480)) dut (
      .pclk      (pclk),
      .rst       (rst),
      .in_de     (in_de),
      .in_hs     (in_hs),
      .in_vs     (in_vs),
      .row1_in   (row1_in),
      .row2_in   (row2_in),
      .row3_in   (row3_in),
      .thresh    (thresh),
      .out_de    (out_de),
      .out_hs    (out_hs),
      .out_vs    (out_vs),
      .out_data  (out_data),
      .edge_flag (edge_flag)
   );

   typedef struct {
      int   stamp;
      logic hs;
      logic vs;
      logic white;
   } exp_t;

   exp_t sb [$];
   exp_t e;
   int   cyc    = 0;
   int   n_chk  = 0;
   int   n_fail = 0;
   logic mon_en = 1'b0;
   logic rst_q  = 1'b0;

   always @(posedge pclk) begin
      cyc   <= cyc + 1;
      rst_q <= rst;
   end

   // ---------------- monitor -----------------------------------------------
   always @(negedge pclk) begin
      if (mon_en) begin
         if (rst_q) begin
            n_chk++;
            if (out_de || out_hs || out_vs || out_data != 16'h0 || edge_flag) begin
               n_fail++;
               $display("FAIL reset_outputs: de=%b hs=%b vs=%b data=%h edge=%b, want all 0",
                        out_de, out_hs, out_vs, out_data, edge_flag);
            end
         end else if (out_de) begin
            n_chk++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_beat: out_de=1 at cycle %0d, want no beat", cyc);
            end else begin
               e = sb.pop_front();
               if (cyc - e.stamp != 4) begin
                  n_fail++;
                  $display("FAIL latency: got %0d cycles, want 4", cyc - e.stamp);
               end
               n_chk++;
               if (out_hs !== e.hs || out_vs !== e.vs) begin
                  n_fail++;
                  $display("FAIL sync_align: got hs=%b vs=%b, want hs=%b vs=%b",
                           out_hs, out_vs, e.hs, e.vs);
               end
               n_chk++;
               if (out_data !== (e.white ? 16'hFFFF : 16'h0000)) begin
                  n_fail++;
                  $display("FAIL out_data: got %h, want %h (issued cycle %0d)",
                           out_data, e.white ? 16'hFFFF : 16'h0000, e.stamp);
               end
               n_chk++;
               if (edge_flag !== e.white) begin
                  n_fail++;
                  $display("FAIL edge_flag: got %b, want %b (issued cycle %0d)",
                           edge_flag, e.white, e.stamp);
               end
            end
         end else begin
            n_chk++;
            if (out_data != 16'h0 || edge_flag) begin
               n_fail++;
               $display("FAIL idle_outputs: data=%h edge=%b with out_de=0, want 0",
                        out_data, edge_flag);
            end
         end
      end
   end

   // ---------------- driver ------------------------------------------------
   task automatic step(input logic r, input logic de, input logic hs, input logic vs,
                       input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                       input logic [7:0] th, input logic white);
      @(posedge pclk);
      #1;
      rst = r; in_de = de; in_hs = hs; in_vs = vs;
      row1_in = a; row2_in = b; row3_in = c; thresh = th;
      if (r) begin
         // Beats issued in the last three cycles are still in flight and die.
         while (sb.size() > 0 && sb[$].stamp >= cyc - 3) void'(sb.pop_back());
      end else if (de) begin
         sb.push_back('{stamp: cyc, hs: hs, vs: vs, white: white});
      end
   endtask

   function automatic logic [7:0] mode_th(input int mode);
      case (mode)
         M_VERT:  return 8'd128;
         M_HORIZ: return 8'd255;
         M_ZERO:  return 8'd0;
         default: return 8'd1;
      endcase
   endfunction

   // Hand-derived expectation per mode: line L, output column k.
   function automatic logic exp_white(input int mode, input int L, input int k);
      case (mode)
         M_VERT:          return (L >= 2) && (k == 8 || k == 9);
         M_HORIZ, M_ZERO: return (L >= 2) && (k >= 2);
         default:         return 1'b0;
      endcase
   endfunction

   task automatic beat(input int mode, input int L, input int k);
      logic [15:0] a, b, c;
      case (mode)
         M_VERT:  begin a = (k < 8) ? 16'h0000 : 16'hFFFF; b = a; c = a; end
         M_HORIZ: begin a = 16'h0000; b = 16'hFFFF; c = 16'hFFFF; end
         default: begin a = 16'hFFFF; b = 16'hFFFF; c = 16'hFFFF; end
      endcase
      step(1'b0, 1'b1, L[0], 1'b0, a, b, c, mode_th(mode), exp_white(mode, L, k));
   endtask

   task automatic blank(input int mode);
      for (int i = 0; i < 6; i++)
         step(1'b0, 1'b0, (i == 1 || i == 2), 1'b0, '0, '0, '0, mode_th(mode), 1'b0);
   endtask

   task automatic frame(input int mode, input int nlines, input int width);
      for (int i = 0; i < 4; i++)
         step(1'b0, 1'b0, 1'b0, (i < 2), '0, '0, '0, mode_th(mode), 1'b0);
      for (int L = 0; L < nlines; L++) begin
         for (int k = 0; k < width; k++) beat(mode, L, k);
         blank(mode);
      end
   endtask

   // ---------------- stimulus ----------------------------------------------
   initial begin
      rst = 1'b1; in_de = 1'b1;
      row1_in = 16'hFFFF; row2_in = 16'hFFFF; row3_in = 16'hFFFF; thresh = 8'd1;
      @(posedge pclk);
      #1;
      mon_en = 1'b1;
      // Reset held five cycles with live data on the inputs.
      for (int i = 0; i < 4; i++)
         step(1'b1, 1'b1, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 8'd1, 1'b0);
      // Data continues straight out of reset: line 0, all black.
      for (int k = 0; k < 16; k++)
         step(1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 8'd1, 1'b0);
      blank(M_FLAT);

      frame(M_FLAT,  4, 16);
      frame(M_VERT,  4, 16);
      frame(M_HORIZ, 3, 16);
      frame(M_ZERO,  3, 16);

      // Reset in the middle of line 5, column 100.
      frame(M_HORIZ, 5, 16);
      for (int k = 0; k < 100; k++) beat(M_HORIZ, 5, k);
      for (int i = 0; i < 3; i++)
         step(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'hFFFF, 16'hFFFF, 8'd255, 1'b0);
      for (int i = 0; i < 6; i++)
         step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 8'd255, 1'b0);
      frame(M_HORIZ, 3, 16);

      for (int i = 0; i < 10; i++)
         step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 8'd1, 1'b0);
      @(negedge pclk);
      n_chk++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL missing_beats: %0d expected beats never appeared, want 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
